// File: rtl/board_renderer.sv
// Redraws the 6x7 Connect-4 board and the column cursor strip into the VGA frame buffer.
// Optional HIGHLIGHT_WIN_EN adds a win_mask input that paints flagged cells green.
module board_renderer #(
  parameter int unsigned X0       = 16,
  parameter int unsigned Y0       = 100,
  parameter int unsigned PITCH    = 16,
  parameter int unsigned CELL     = 12,
  parameter int unsigned CURSOR_Y = 4,
  parameter int unsigned CURSOR_H = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic [2:0]  cursor_col,
  output logic [5:0]  rd_addr,
  input  logic [1:0]  rd_data,
`ifdef HIGHLIGHT_WIN_EN
  input  logic [41:0] win_mask,
`endif
  output logic [7:0]  x,
  output logic [6:0]  y,
  output logic [2:0]  colour,
  output logic        plot,
  output logic        busy,
  output logic        done
);

  typedef enum logic [2:0] {S_IDLE, S_FETCH, S_WAIT, S_DRAW, S_CURSOR, S_DONE} state_t;

  state_t      state_q, state_d;
  logic [5:0]  rd_addr_q, rd_addr_d;
  logic [2:0]  row_q, row_d, col_q, col_d, cur_q, cur_d, cellc_q, cellc_d;
  logic [7:0]  px_q, px_d, py_q, py_d;
  logic [7:0]  x_q, x_d;
  logic [6:0]  y_q, y_d;
  logic [2:0]  colour_q, colour_d;
  logic        plot_q, plot_d, busy_q, busy_d, done_q, done_d;
  logic        px_last, py_cell_last, py_cur_last;

  function automatic logic [2:0] map_code(input logic [1:0] code);
    case (code)
      2'b00:   map_code = 3'b001;
      2'b01:   map_code = 3'b100;
      2'b10:   map_code = 3'b110;
      default: map_code = 3'b111;
    endcase
  endfunction

  assign px_last      = (px_q == 8'(CELL - 1));
  assign py_cell_last = (py_q == 8'(CELL - 1));
  assign py_cur_last  = (py_q == 8'(CURSOR_H - 1));

  always_comb begin
    state_d   = state_q;
    rd_addr_d = rd_addr_q;
    row_d     = row_q;
    col_d     = col_q;
    cur_d     = cur_q;
    cellc_d   = cellc_q;
    px_d      = px_q;
    py_d      = py_q;
    x_d       = x_q;
    y_d       = y_q;
    colour_d  = colour_q;
    busy_d    = busy_q;
    plot_d    = 1'b0;
    done_d    = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          cur_d     = cursor_col;
          busy_d    = 1'b1;
          rd_addr_d = '0;
          row_d     = '0;
          col_d     = '0;
          state_d   = S_FETCH;
        end
      end
      S_FETCH: state_d = S_WAIT;
      S_WAIT: begin
`ifdef HIGHLIGHT_WIN_EN
        cellc_d = win_mask[rd_addr_q] ? 3'b010 : map_code(rd_data);
`else
        cellc_d = map_code(rd_data);
`endif
        px_d    = '0;
        py_d    = '0;
        state_d = S_DRAW;
      end
      S_DRAW: begin
        plot_d   = 1'b1;
        x_d      = 8'(X0 + 32'(col_q) * PITCH + 32'(px_q));
        y_d      = 7'(Y0 - 32'(row_q) * PITCH + 32'(py_q));
        colour_d = cellc_q;
        if (!px_last) begin
          px_d = px_q + 8'd1;
        end else begin
          px_d = '0;
          if (!py_cell_last) begin
            py_d = py_q + 8'd1;
          end else begin
            py_d = '0;
            if (rd_addr_q == 6'd41) begin
              col_d   = '0;
              state_d = S_CURSOR;
            end else begin
              // rd_addr tracks row*7+col so the column wrap bumps the row
              rd_addr_d = rd_addr_q + 6'd1;
              if (col_q == 3'd6) begin
                col_d = '0;
                row_d = row_q + 3'd1;
              end else begin
                col_d = col_q + 3'd1;
              end
              state_d = S_FETCH;
            end
          end
        end
      end
      S_CURSOR: begin
        plot_d   = 1'b1;
        x_d      = 8'(X0 + 32'(col_q) * PITCH + 32'(px_q));
        y_d      = 7'(CURSOR_Y + 32'(py_q));
        colour_d = (col_q == cur_q) ? 3'b111 : 3'b000;
        if (!px_last) begin
          px_d = px_q + 8'd1;
        end else begin
          px_d = '0;
          if (!py_cur_last) begin
            py_d = py_q + 8'd1;
          end else begin
            py_d = '0;
            if (col_q == 3'd6) state_d = S_DONE;
            else               col_d   = col_q + 3'd1;
          end
        end
      end
      S_DONE: begin
        done_d  = 1'b1;
        busy_d  = 1'b0;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= S_IDLE;
      rd_addr_q <= '0;
      row_q     <= '0;
      col_q     <= '0;
      cur_q     <= '0;
      cellc_q   <= '0;
      px_q      <= '0;
      py_q      <= '0;
      x_q       <= '0;
      y_q       <= '0;
      colour_q  <= '0;
      plot_q    <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      rd_addr_q <= rd_addr_d;
      row_q     <= row_d;
      col_q     <= col_d;
      cur_q     <= cur_d;
      cellc_q   <= cellc_d;
      px_q      <= px_d;
      py_q      <= py_d;
      x_q       <= x_d;
      y_q       <= y_d;
      colour_q  <= colour_d;
      plot_q    <= plot_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
    end
  end

  assign rd_addr = rd_addr_q;
  assign x       = x_q;
  assign y       = y_q;
  assign colour  = colour_q;
  assign plot    = plot_q;
  assign busy    = busy_q;
  assign done    = done_q;

endmodule

// File: tb/tb_board_renderer.sv
// Bench for board_renderer: pixel-list model of a full redraw checked on every plot.
module tb_board_renderer;
  localparam int X0 = 16, Y0 = 100, PITCH = 16, CELL = 12, CURSOR_Y = 4, CURSOR_H = 4;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       start = 1'b0;
  logic [2:0] cursor_col = '0;
  logic [5:0] rd_addr;
  logic [1:0] rd_data = '0;
  logic [7:0] x;
  logic [6:0] y;
  logic [2:0] colour;
  logic       plot, busy, done;
`ifdef HIGHLIGHT_WIN_EN
  logic [41:0] win_mask = '0;
`endif

  board_renderer #(.X0(X0), .Y0(Y0), .PITCH(PITCH), .CELL(CELL),
                   .CURSOR_Y(CURSOR_Y), .CURSOR_H(CURSOR_H)) dut (
    .clk(clk), .rst(rst), .start(start), .cursor_col(cursor_col),
    .rd_addr(rd_addr), .rd_data(rd_data),
`ifdef HIGHLIGHT_WIN_EN
    .win_mask(win_mask),
`endif
    .x(x), .y(y), .colour(colour), .plot(plot), .busy(busy), .done(done));

  always #5 clk = ~clk;

  logic [1:0] mem [0:41];
  always @(posedge clk) rd_data <= mem[rd_addr];

  typedef struct { logic [7:0] px; logic [6:0] py; logic [2:0] pc; } pix_t;
  pix_t       expq[$];
  int         alog[$];
  logic [2:0] fb [0:255][0:127];
  int n_chk = 0, n_fail = 0, plot_cnt = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  function automatic logic [31:0] pk(input int px, input int py, input int pc);
    return {14'd0, 8'(px), 7'(py), 3'(pc)};
  endfunction

  function automatic logic [2:0] cmap(input logic [1:0] code);
    case (code)
      2'b00: return 3'b001;
      2'b01: return 3'b100;
      2'b10: return 3'b110;
      default: return 3'b111;
    endcase
  endfunction

  // Expected picture as an ordered list of pixel writes.
  task automatic build_model(input logic [2:0] cur);
    int r, c;
    logic [2:0] col;
    expq.delete();
    for (int a = 0; a < 42; a++) begin
      r = a / 7;
      c = a % 7;
      col = cmap(mem[a]);
`ifdef HIGHLIGHT_WIN_EN
      if (win_mask[a]) col = 3'b010;
`endif
      for (int py = 0; py < CELL; py++)
        for (int px = 0; px < CELL; px++)
          expq.push_back('{8'(X0 + c*PITCH + px), 7'(Y0 - r*PITCH + py), col});
    end
    for (int cc = 0; cc < 7; cc++)
      for (int py = 0; py < CURSOR_H; py++)
        for (int px = 0; px < CELL; px++)
          expq.push_back('{8'(X0 + cc*PITCH + px), 7'(CURSOR_Y + py),
                           (cc == int'(cur)) ? 3'b111 : 3'b000});
  endtask

  always @(negedge clk) begin
    if (rst) begin
      if (plot) begin
        pix_t e;
        plot_cnt++;
        fb[x][y] = colour;
        if (expq.size() == 0) chk("unexpected_plot", pk(x, y, colour), 32'hFFFF_FFFF);
        else begin
          e = expq.pop_front();
          chk("pixel", pk(x, y, colour), pk(e.px, e.py, e.pc));
        end
      end
      if (busy) begin
        chk("rd_addr_range", {31'd0, rd_addr > 6'd41}, 32'd0);
        if (alog.size() == 0 || alog[$] != int'(rd_addr)) alog.push_back(int'(rd_addr));
      end
    end
  end

  // Called just after a posedge; returns just after the edge where done is visible.
  task automatic run(input logic [2:0] cur, input bit repulse);
    int k, pc0;
    bit got;
    build_model(cur);
    alog.delete();
    pc0 = plot_cnt;
    start = 1'b1;
    cursor_col = cur;
    @(posedge clk); #1;
    start = 1'b0;
    k = 0;
    got = 0;
    while (!got && k < 8000) begin
      @(posedge clk); #1;
      k++;
      if (repulse && k == 100) begin start = 1'b1; cursor_col = 3'd5; end
      else if (repulse && k == 101) start = 1'b0;
      if (k == 1) begin
        chk("busy_after_start", {31'd0, busy}, 32'd1);
        chk("done_low_after_start", {31'd0, done}, 32'd0);
      end
      if (done) got = 1;
    end
    chk("done_seen", {31'd0, got}, 32'd1);
    chk("done_latency", k, 6469);
    chk("busy_at_done", {31'd0, busy}, 32'd0);
    chk("plot_low_at_done", {31'd0, plot}, 32'd0);
    chk("plot_count", plot_cnt - pc0, 6384);
    chk("model_drained", expq.size(), 0);
    chk("addr_count", alog.size(), 42);
    for (int i = 0; i < alog.size(); i++) chk("addr_seq", alog[i], i);
  endtask

  initial begin
    int pc0;
    for (int i = 0; i < 256; i++)
      for (int j = 0; j < 128; j++) fb[i][j] = 3'b101;
    for (int i = 0; i < 42; i++) mem[i] = 2'b00;

    #3 rst = 1'b0;
    #1;
    chk("rst_plot", {31'd0, plot}, 0);
    chk("rst_busy", {31'd0, busy}, 0);
    chk("rst_done", {31'd0, done}, 0);
    chk("rst_x", {24'd0, x}, 0);
    chk("rst_y", {25'd0, y}, 0);
    chk("rst_colour", {29'd0, colour}, 0);
    chk("rst_rd_addr", {26'd0, rd_addr}, 0);
    @(negedge clk); @(negedge clk);
    rst = 1'b1;
    @(posedge clk); #1;

    build_model(3'd0);
    chk("model_first", pk(expq[0].px, expq[0].py, expq[0].pc), pk(16, 100, 1));
    chk("model_cell0_last", pk(expq[143].px, expq[143].py, expq[143].pc), pk(27, 111, 1));
    chk("model_cursor_first", pk(expq[6048].px, expq[6048].py, expq[6048].pc), pk(16, 4, 7));

    // Empty board, cursor on column 0.
    run(3'd0, 1'b0);
    chk("fb_empty_cell", {29'd0, fb[16][100]}, 3'b001);
    chk("fb_marker0_tl", {29'd0, fb[16][4]}, 3'b111);
    chk("fb_marker0_br", {29'd0, fb[27][7]}, 3'b111);
    chk("fb_gap_untouched", {29'd0, fb[28][4]}, 3'b101);
    chk("fb_marker1", {29'd0, fb[32][4]}, 3'b000);

    // Corner cells populated, start re-pulsed mid-redraw, then chained start.
    mem[0] = 2'b01;
    mem[41] = 2'b10;
    @(posedge clk); #1;
    run(3'd3, 1'b1);
    chk("fb_cell0_red", {29'd0, fb[16][100]}, 3'b100);
    chk("fb_cell41_yellow", {29'd0, fb[112][20]}, 3'b110);
    chk("fb_marker3", {29'd0, fb[64][4]}, 3'b111);
    chk("fb_marker0_cleared", {29'd0, fb[16][4]}, 3'b000);
    run(3'd7, 1'b0);
    chk("fb_cur7_m3", {29'd0, fb[64][4]}, 3'b000);
    chk("fb_cur7_m6", {29'd0, fb[112][7]}, 3'b000);

    // Reset in the middle of drawing cell 0.
    @(posedge clk); #1;
    build_model(3'd0);
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (50) @(posedge clk);
    #2 rst = 1'b0;
    #1;
    chk("midrst_plot", {31'd0, plot}, 0);
    chk("midrst_busy", {31'd0, busy}, 0);
    chk("midrst_rd_addr", {26'd0, rd_addr}, 0);
    expq.delete();
    @(negedge clk);
    rst = 1'b1;
    pc0 = plot_cnt;
    repeat (20) @(posedge clk);
    #1;
    chk("post_rst_no_plot", plot_cnt - pc0, 0);
    chk("post_rst_idle", {31'd0, busy}, 0);

    // Mixed board including the illegal code.
    for (int i = 0; i < 42; i++) mem[i] = 2'(i % 4);
    run(3'd6, 1'b0);
    chk("fb_mixed_red", {29'd0, fb[32][100]}, 3'b100);
    chk("fb_mixed_white", {29'd0, fb[64][100]}, 3'b111);
    chk("fb_marker6", {29'd0, fb[112][4]}, 3'b111);

`ifdef HIGHLIGHT_WIN_EN
    for (int i = 0; i < 42; i++) mem[i] = 2'b01;
    win_mask = 42'hF;
    @(posedge clk); #1;
    run(3'd0, 1'b0);
    chk("fb_win_cell0", {29'd0, fb[16][100]}, 3'b010);
    chk("fb_win_cell3", {29'd0, fb[64][100]}, 3'b010);
    chk("fb_win_cell4", {29'd0, fb[80][100]}, 3'b100);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
